// File: rtl/link_wb_ctrl.sv
// rtl/link_wb_ctrl.sv - R15 link register write-port controller with JR hazard/forwarding
//
// Purpose:
//   Tracks JAL return addresses from issue (ID) through PIPE_DEPTH stages to
//   writeback, drives the R15 register's enable/data/stall, arbitrates the JAL
//   writeback against ordinary register-file writes to R15, and protects JR
//   from reading a stale R15 (hazard request or same-cycle forwarding).
//
// Optional feature macro: LINK_FWD_EN
//   defined   -> a same-cycle write to R15 is forwarded to JR (no bubble)
//   undefined -> forwarding outputs tied to 0, JR stalls one extra cycle
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_stall_in            global pipeline stall (chain holds, WB deferred)
//   i_flush               kill in-flight JALs not entering WB
//   i_jal_issue, i_jal_pc JAL in ID and its return address
//   i_rf_wr_*             normal WB register-file write
//   i_jr_req              JR in ID needs R15
//   o_link_en/_data       R15 write enable and data
//   o_link_stall          hold request to R15
//   o_jr_hazard           stall request to fetch/decode
//   o_jr_fwd_valid/_data  forwarded newest R15 value
//   o_collide             rf write to R15 dropped in favour of JAL
//   o_pend_cnt            number of in-flight JALs
//   o_busy                controller not IDLE

module link_wb_ctrl #(
  parameter int DATA_W     = 16,
  parameter int PIPE_DEPTH = 3,
  localparam int CNT_W     = $clog2(PIPE_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall_in,
  input  logic              i_flush,
  input  logic              i_jal_issue,
  input  logic [DATA_W-1:0] i_jal_pc,
  input  logic              i_rf_wr_en,
  input  logic [3:0]        i_rf_wr_addr,
  input  logic [DATA_W-1:0] i_rf_wr_data,
  input  logic              i_jr_req,
  output logic              o_link_en,
  output logic [DATA_W-1:0] o_link_data,
  output logic              o_link_stall,
  output logic              o_jr_hazard,
  output logic              o_jr_fwd_valid,
  output logic [DATA_W-1:0] o_jr_fwd_data,
  output logic              o_collide,
  output logic [CNT_W-1:0]  o_pend_cnt,
  output logic              o_busy
);

  localparam int WB = PIPE_DEPTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

  state_t                r_state;
  logic [PIPE_DEPTH-1:0] r_v;
  logic [DATA_W-1:0]     r_addr [PIPE_DEPTH];
  logic [CNT_W-1:0]      r_pend_cnt;

  logic [PIPE_DEPTH-1:0] w_next_v;
  logic [DATA_W-1:0]     w_next_addr [PIPE_DEPTH];
  logic [CNT_W-1:0]      w_next_cnt;
  logic                  w_jal_wb;
  logic                  w_rf_hit;
  logic                  w_link_en;
  logic [DATA_W-1:0]     w_link_data;
  logic                  w_early_pend;

  // Next chain contents. A flush clears every stage the chain would load
  // except WB, so the JAL about to enter WB still retires next cycle.
  always_comb begin
    w_next_v    = r_v;
    w_next_addr = r_addr;
    if (!i_stall_in) begin
      w_next_v[0]    = i_jal_issue & ~i_flush;
      w_next_addr[0] = i_jal_pc;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        w_next_v[i]    = r_v[i-1] & (~i_flush | (i == WB));
        w_next_addr[i] = r_addr[i-1];
      end
    end
  end

  // Registered popcount of the next valids keeps pend_cnt aligned with r_v.
  always_comb begin
    w_next_cnt = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      w_next_cnt = w_next_cnt + CNT_W'(w_next_v[i]);
    end
  end

  assign w_jal_wb     = r_v[WB] & ~i_stall_in;
  assign w_rf_hit     = i_rf_wr_en & (i_rf_wr_addr == 4'hF) & ~i_stall_in;
  assign w_link_en    = w_jal_wb | w_rf_hit;
  assign w_link_data  = w_jal_wb ? r_addr[WB] : (w_rf_hit ? i_rf_wr_data : '0);
  assign w_early_pend = |r_v[WB-1:0];

  assign o_link_en    = w_link_en;
  assign o_link_data  = w_link_data;
  assign o_link_stall = i_stall_in;
  assign o_collide    = w_jal_wb & w_rf_hit;
  assign o_pend_cnt   = r_pend_cnt;
  assign o_busy       = (r_state != S_IDLE);

`ifdef LINK_FWD_EN
  // The value being written this cycle is the newest R15; hand it to JR.
  assign o_jr_fwd_valid = i_jr_req & w_link_en;
  assign o_jr_fwd_data  = (i_jr_req & w_link_en) ? w_link_data : '0;
  assign o_jr_hazard    = i_jr_req & w_early_pend;
`else
  // Without forwarding, JR waits until the R15 write has landed.
  assign o_jr_fwd_valid = 1'b0;
  assign o_jr_fwd_data  = '0;
  assign o_jr_hazard    = i_jr_req & (w_early_pend | w_link_en);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v        <= '0;
      r_pend_cnt <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_v        <= w_next_v;
      r_pend_cnt <= w_next_cnt;
      case (r_state)
        S_IDLE: begin
          if (w_next_cnt != '0) r_state <= S_TRACK;
        end
        S_TRACK: begin
          if (w_next_cnt == '0) r_state <= S_IDLE;
          else if (i_stall_in)  r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!i_stall_in) r_state <= (w_next_cnt == '0) ? S_IDLE : S_TRACK;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge i_clk) begin
    r_addr <= w_next_addr;
  end

endmodule

// File: tb/tb_link_wb_ctrl.sv
// tb/tb_link_wb_ctrl.sv - self-checking bench for link_wb_ctrl

module tb_link_wb_ctrl;

  localparam int DW = 16;
  localparam int PD = 3;
  localparam int CW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_stall_in;
  logic          i_flush;
  logic          i_jal_issue;
  logic [DW-1:0] i_jal_pc;
  logic          i_rf_wr_en;
  logic [3:0]    i_rf_wr_addr;
  logic [DW-1:0] i_rf_wr_data;
  logic          i_jr_req;
  logic          o_link_en;
  logic [DW-1:0] o_link_data;
  logic          o_link_stall;
  logic          o_jr_hazard;
  logic          o_jr_fwd_valid;
  logic [DW-1:0] o_jr_fwd_data;
  logic          o_collide;
  logic [CW-1:0] o_pend_cnt;
  logic          o_busy;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q_exp[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  link_wb_ctrl #(.DATA_W(DW), .PIPE_DEPTH(PD)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_stall_in     (i_stall_in),
    .i_flush        (i_flush),
    .i_jal_issue    (i_jal_issue),
    .i_jal_pc       (i_jal_pc),
    .i_rf_wr_en     (i_rf_wr_en),
    .i_rf_wr_addr   (i_rf_wr_addr),
    .i_rf_wr_data   (i_rf_wr_data),
    .i_jr_req       (i_jr_req),
    .o_link_en      (o_link_en),
    .o_link_data    (o_link_data),
    .o_link_stall   (o_link_stall),
    .o_jr_hazard    (o_jr_hazard),
    .o_jr_fwd_valid (o_jr_fwd_valid),
    .o_jr_fwd_data  (o_jr_fwd_data),
    .o_collide      (o_collide),
    .o_pend_cnt     (o_pend_cnt),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc = cyc + 1;

  // Scoreboard: every R15 write must match the oldest expected write.
  always @(negedge i_clk) begin
    if (o_link_en !== 1'b0) begin
      n_tests++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL link_write_unexpected: cycle %0d got data %h, expected no write", cyc, o_link_data);
      end else begin
        m_e = q_exp.pop_front();
        if (m_e.cyc != cyc || o_link_data !== m_e.data) begin
          n_fail++;
          $display("FAIL link_write: got cycle %0d data %h, expected cycle %0d data %h",
                   cyc, o_link_data, m_e.cyc, m_e.data);
        end
      end
    end
  end

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle;
    i_stall_in   = 1'b0;
    i_flush      = 1'b0;
    i_jal_issue  = 1'b0;
    i_jal_pc     = '0;
    i_rf_wr_en   = 1'b0;
    i_rf_wr_addr = '0;
    i_rf_wr_data = '0;
    i_jr_req     = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({o_link_en, o_link_data, o_link_stall, o_jr_hazard, o_jr_fwd_valid,
           o_jr_fwd_data, o_collide} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs k=%0d: got en=%b data=%h stall=%b haz=%b fv=%b fd=%h col=%b, expected all 0",
                 k, o_link_en, o_link_data, o_link_stall, o_jr_hazard, o_jr_fwd_valid, o_jr_fwd_data, o_collide);
      end
      n_tests++;
      if (o_pend_cnt !== '0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state k=%0d: got pend_cnt=%0d busy=%b, expected 0 0", k, o_pend_cnt, o_busy);
      end
      step();
    end
  endtask

  task automatic test_basic;
    int c0;
    int e;
    idle();
    c0 = cyc;
    i_jal_issue = 1'b1;
    i_jal_pc    = 16'h0042;
    q_exp.push_back('{c0 + 3, 16'h0042});
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) idle();
      #1;
      e = (k >= 1 && k <= 3) ? 1 : 0;
      n_tests++;
      if (o_pend_cnt !== CW'(e) || o_busy !== (e != 0)) begin
        n_fail++;
        $display("FAIL basic_pend k=%0d: got pend_cnt=%0d busy=%b, expected %0d %b", k, o_pend_cnt, o_busy, e, (e != 0));
      end
      step();
    end
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL basic_missing_write: %0d writes outstanding, expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  task automatic test_stall;
    int c0;
    int e;
    logic es;
    idle();
    c0 = cyc;
    i_jal_issue = 1'b1;
    i_jal_pc    = 16'h0100;
    q_exp.push_back('{c0 + 5, 16'h0100});
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) idle();
      es = (k == 2 || k == 3);
      i_stall_in = es;
      if (k == 3) i_flush = 1'b1;
      #1;
      n_tests++;
      if (o_link_stall !== es) begin
        n_fail++;
        $display("FAIL stall_link_stall k=%0d: got %b, expected %b", k, o_link_stall, es);
      end
      e = (k >= 1 && k <= 5) ? 1 : 0;
      n_tests++;
      if (o_pend_cnt !== CW'(e) || o_busy !== (e != 0)) begin
        n_fail++;
        $display("FAIL stall_pend k=%0d: got pend_cnt=%0d busy=%b, expected %0d %b", k, o_pend_cnt, o_busy, e, (e != 0));
      end
      step();
    end
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL stall_missing_write: %0d writes outstanding, expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  task automatic test_collide;
    int c0;
    idle();
    c0 = cyc;
    i_jal_issue = 1'b1;
    i_jal_pc    = 16'h0077;
    q_exp.push_back('{c0 + 3, 16'h0077});
    q_exp.push_back('{c0 + 4, 16'h1234});
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) idle();
      if (k == 3 || k == 4) begin
        i_rf_wr_en   = 1'b1;
        i_rf_wr_addr = 4'hF;
        i_rf_wr_data = 16'h1234;
      end else if (k == 5) begin
        i_rf_wr_en   = 1'b1;
        i_rf_wr_addr = 4'hE;
        i_rf_wr_data = 16'h5555;
      end
      #1;
      n_tests++;
      if (o_collide !== (k == 3)) begin
        n_fail++;
        $display("FAIL collide k=%0d: got %b, expected %b", k, o_collide, (k == 3));
      end
      step();
    end
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL collide_missing_write: %0d writes outstanding, expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  task automatic test_jr;
    int c0;
    logic eh;
    logic efv;
    logic [DW-1:0] efd;
    idle();
    c0 = cyc;
    i_jal_issue = 1'b1;
    i_jal_pc    = 16'h0ABC;
    q_exp.push_back('{c0 + 3, 16'h0ABC});
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        idle();
        i_jr_req = 1'b1;
      end
`ifdef LINK_FWD_EN
      eh  = (k == 1 || k == 2);
      efv = (k == 3);
      efd = (k == 3) ? 16'h0ABC : 16'h0000;
`else
      eh  = (k >= 1 && k <= 3);
      efv = 1'b0;
      efd = 16'h0000;
`endif
      #1;
      n_tests++;
      if (o_jr_hazard !== eh) begin
        n_fail++;
        $display("FAIL jr_hazard k=%0d: got %b, expected %b", k, o_jr_hazard, eh);
      end
      n_tests++;
      if (o_jr_fwd_valid !== efv || o_jr_fwd_data !== efd) begin
        n_fail++;
        $display("FAIL jr_fwd k=%0d: got valid=%b data=%h, expected %b %h", k, o_jr_fwd_valid, o_jr_fwd_data, efv, efd);
      end
      step();
    end
    idle();
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL jr_missing_write: %0d writes outstanding, expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  task automatic test_flush;
    int c0;
    int e;
    idle();
    c0 = cyc;
    q_exp.push_back('{c0 + 3, 16'h0011});
    for (int k = 0; k <= 5; k++) begin
      idle();
      if (k <= 2) begin
        i_jal_issue = 1'b1;
        i_jal_pc    = 16'h0011 * DW'(k + 1);
      end
      if (k == 2) i_flush = 1'b1;
      #1;
      case (k)
        1: e = 1;
        2: e = 2;
        3: e = 1;
        default: e = 0;
      endcase
      n_tests++;
      if (o_pend_cnt !== CW'(e) || o_busy !== (e != 0)) begin
        n_fail++;
        $display("FAIL flush_pend k=%0d: got pend_cnt=%0d busy=%b, expected %0d %b", k, o_pend_cnt, o_busy, e, (e != 0));
      end
      step();
    end
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL flush_missing_write: %0d writes outstanding, expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  task automatic test_reset_mid;
    int e;
    idle();
    i_jal_issue = 1'b1;
    i_jal_pc    = 16'h0055;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) idle();
      i_rst = (k == 1);
      #1;
      e = (k == 1) ? 1 : 0;
      if (k >= 1) begin
        n_tests++;
        if (o_pend_cnt !== CW'(e) || o_busy !== (e != 0)) begin
          n_fail++;
          $display("FAIL reset_mid_pend k=%0d: got pend_cnt=%0d busy=%b, expected %0d %b", k, o_pend_cnt, o_busy, e, (e != 0));
        end
      end
      step();
    end
    i_rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int c0;
    int e;
    idle();
    c0 = cyc;
    for (int k = 0; k <= 6; k++) begin
      idle();
      if (k <= 2) begin
        i_jal_issue = 1'b1;
        i_jal_pc    = 16'h0101 + DW'(k);
        q_exp.push_back('{c0 + 3 + k, 16'h0101 + DW'(k)});
      end
      #1;
      case (k)
        1: e = 1;
        2: e = 2;
        3: e = 3;
        4: e = 2;
        5: e = 1;
        default: e = 0;
      endcase
      n_tests++;
      if (o_pend_cnt !== CW'(e)) begin
        n_fail++;
        $display("FAIL b2b_pend k=%0d: got pend_cnt=%0d, expected %0d", k, o_pend_cnt, e);
      end
      step();
    end
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing_write: %0d writes outstanding, expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_stall();
    test_collide();
    test_jr();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
